// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin APB arbiter: replays the winning requester's transfer on a
// single registered downstream APB port and aborts slaves that exceed the wait-state budget.
module apb_req_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  m0_psel,
    input  logic                  m0_penable,
    input  logic [ADDR_WIDTH-1:0] m0_paddr,
    input  logic                  m0_pwrite,
    input  logic [DATA_WIDTH-1:0] m0_pwdata,
    output logic [DATA_WIDTH-1:0] m0_prdata,
    output logic                  m0_pready,
    output logic                  m0_pslverr,
    input  logic                  m1_psel,
    input  logic                  m1_penable,
    input  logic [ADDR_WIDTH-1:0] m1_paddr,
    input  logic                  m1_pwrite,
    input  logic [DATA_WIDTH-1:0] m1_pwdata,
    output logic [DATA_WIDTH-1:0] m1_prdata,
    output logic                  m1_pready,
    output logic                  m1_pslverr,
    output logic                  psel,
    output logic                  penable,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic [1:0]            grant,
    output logic                  timeout_evt
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
    localparam logic          TO_EN    = (TIMEOUT > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [1:0]            grant_q, grant_d;
    logic                  tevt_q, tevt_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ptr_q, ptr_d;

    logic [1:0]            req_s;
    logic                  win_s;
    logic                  abort_s;
    logic                  resp_vld_s;
    logic [DATA_WIDTH-1:0] resp_data_s;
    logic                  resp_err_s;

    assign req_s   = {m1_psel, m0_psel};
    assign abort_s = (state_q == ST_ACCESS) && !pready && TO_EN && (cnt_q == CNT_LAST);

    // Winner selection: a lone requester wins outright, a tie goes to the pointer.
    always_comb begin
        win_s = 1'b0;
        case (req_s)
            2'b01:   win_s = 1'b0;
            2'b10:   win_s = 1'b1;
            2'b11:   win_s = ptr_q;
            default: win_s = 1'b0;
        endcase
    end

    // Next-state logic for the transfer sequencer and downstream bus registers.
    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        grant_d   = grant_q;
        tevt_d    = 1'b0;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s != 2'b00) begin
                    state_d   = ST_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = win_s ? m1_paddr  : m0_paddr;
                    pwrite_d  = win_s ? m1_pwrite : m0_pwrite;
                    pwdata_d  = win_s ? m1_pwdata : m0_pwdata;
                    grant_d   = win_s ? 2'b10 : 2'b01;
                    ptr_d     = ~win_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = {CW{1'b0}};
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready || abort_s) begin
                    state_d   = ST_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    paddr_d   = {ADDR_WIDTH{1'b0}};
                    pwrite_d  = 1'b0;
                    pwdata_d  = {DATA_WIDTH{1'b0}};
                    grant_d   = 2'b00;
                    tevt_d    = !pready;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and downstream register bank.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= {ADDR_WIDTH{1'b0}};
            pwrite_q  <= 1'b0;
            pwdata_q  <= {DATA_WIDTH{1'b0}};
            grant_q   <= 2'b00;
            tevt_q    <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            ptr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            grant_q   <= grant_d;
            tevt_q    <= tevt_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    // Completion is routed straight through so the owner sees pready in the slave's cycle.
    assign resp_vld_s  = (state_q == ST_ACCESS) && (pready || abort_s);
    assign resp_data_s = pready ? prdata : {DATA_WIDTH{1'b0}};
    assign resp_err_s  = pready ? pslverr : 1'b1;

    assign m0_pready  = resp_vld_s && grant_q[0];
    assign m0_pslverr = m0_pready && resp_err_s;
    assign m0_prdata  = m0_pready ? resp_data_s : {DATA_WIDTH{1'b0}};
    assign m1_pready  = resp_vld_s && grant_q[1];
    assign m1_pslverr = m1_pready && resp_err_s;
    assign m1_prdata  = m1_pready ? resp_data_s : {DATA_WIDTH{1'b0}};

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign grant       = grant_q;
    assign timeout_evt = tevt_q;

    logic unused_s;
    assign unused_s = m0_penable ^ m1_penable;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: vector table of single transfers plus
// hand-written timeout, contention and mid-transfer reset sequences.
module tb_apb_req_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          reset;
    logic          m0_psel, m0_penable, m0_pwrite, m0_pready, m0_pslverr;
    logic [AW-1:0] m0_paddr;
    logic [DW-1:0] m0_pwdata, m0_prdata;
    logic          m1_psel, m1_penable, m1_pwrite, m1_pready, m1_pslverr;
    logic [AW-1:0] m1_paddr;
    logic [DW-1:0] m1_pwdata, m1_prdata;
    logic          psel, penable, pwrite, s_pready, s_pslverr, timeout_evt;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, s_prdata;
    logic [1:0]    grant;

    apb_req_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .reset(reset),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_paddr(m0_paddr), .m0_pwrite(m0_pwrite),
        .m0_pwdata(m0_pwdata), .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_paddr(m1_paddr), .m1_pwrite(m1_pwrite),
        .m1_pwdata(m1_pwdata), .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(s_prdata), .pready(s_pready), .pslverr(s_pslverr),
        .grant(grant), .timeout_evt(timeout_evt)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        int          waits;
        logic        slverr;
        logic [31:0] rdata;
        logic [31:0] exp_prdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] prdata;
        logic        err;
    } sb_t;

    sb_t  sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[6];

    function automatic vec_t mk(input logic port, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic write, input int waits, input logic slverr,
                                input logic [31:0] rdata, input logic [31:0] exp_prdata,
                                input logic exp_err, input logic exp_to);
        vec_t v;
        v.port = port; v.addr = addr; v.wdata = wdata; v.write = write; v.waits = waits;
        v.slverr = slverr; v.rdata = rdata; v.exp_prdata = exp_prdata;
        v.exp_err = exp_err; v.exp_to = exp_to;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic sb_push(input logic port, input logic [31:0] prd, input logic err);
        sb_t e;
        e.port = port; e.prdata = prd; e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic check_resp(input logic port);
        sb_t e;
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", sb_q.size(), 1);
        end else begin
            e = sb_q.pop_front();
            chk("sb_port", port, e.port);
            chk("sb_prdata", port ? m1_prdata : m0_prdata, e.prdata);
            chk("sb_pslverr", port ? m1_pslverr : m0_pslverr, e.err);
        end
    endtask

    task automatic set_req(input logic port, input logic sel, input logic [31:0] a,
                           input logic [31:0] w, input logic wr);
        if (port) begin
            m1_psel = sel; m1_paddr = a; m1_pwdata = w; m1_pwrite = wr;
        end else begin
            m0_psel = sel; m0_paddr = a; m0_pwdata = w; m0_pwrite = wr;
        end
    endtask

    task automatic do_txn(input vec_t v);
        int   exp_k;
        logic got;
        logic done;
        exp_k = v.exp_to ? TO - 1 : v.waits;
        s_pready = 1'b0; s_pslverr = 1'b0; s_prdata = 32'h0;
        set_req(v.port, 1'b1, v.addr, v.wdata, v.write);
        sb_push(v.port, v.exp_prdata, v.exp_err);
        @(posedge pclk); #1;
        chk("setup_grant", grant, v.port ? 2'b10 : 2'b01);
        chk("setup_psel", psel, 1'b1);
        chk("setup_penable", penable, 1'b0);
        chk("setup_paddr", paddr, v.addr);
        chk("setup_pwrite", pwrite, v.write);
        chk("setup_pwdata", pwdata, v.wdata);
        @(posedge pclk); #1;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            s_pready = (k == v.waits); s_pslverr = v.slverr; s_prdata = v.rdata;
            @(negedge pclk);
            chk("access_penable", penable, 1'b1);
            chk("access_paddr", paddr, v.addr);
            got = v.port ? m1_pready : m0_pready;
            chk("pready_cycle", got, (k == exp_k));
            chk("other_pready", v.port ? m0_pready : m1_pready, 1'b0);
            if (got) begin
                check_resp(v.port);
                done = 1'b1;
            end
            @(posedge pclk); #1;
        end
        chk("txn_done", done, 1'b1);
        set_req(v.port, 1'b0, 32'h0, 32'h0, 1'b0);
        s_pready = 1'b0;
        chk("end_timeout_evt", timeout_evt, v.exp_to);
        chk("end_psel", psel, 1'b0);
        chk("end_grant", grant, 2'b00);
    endtask

    initial begin
        vecs[0] = mk(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 0,  1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        vecs[1] = mk(1'b1, 32'h0000_0040, 32'h0000_0000, 1'b0, 3,  1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
        vecs[2] = mk(1'b0, 32'h0000_0080, 32'h0000_0000, 1'b0, 99, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        vecs[3] = mk(1'b1, 32'h0000_0044, 32'h5555_AAAA, 1'b1, 3,  1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 1'b0);
        vecs[4] = mk(1'b0, 32'h0000_00C0, 32'h0000_0000, 1'b0, 1,  1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1, 1'b0);
        vecs[5] = mk(1'b1, 32'hFFFF_FFFC, 32'h0F0F_0F0F, 1'b1, 0,  1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);

        reset = 1'b1;
        m0_penable = 1'b0; m1_penable = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        s_pready = 1'b0; s_pslverr = 1'b0; s_prdata = 32'h0;
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_timeout_evt", timeout_evt, 1'b0);
        reset = 1'b0;
        @(posedge pclk); #1;

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Timeout on port 0 with port 1 pending behind it.
        set_req(1'b0, 1'b1, 32'h0000_0100, 32'h1111_2222, 1'b1);
        s_pready = 1'b0;
        sb_push(1'b0, 32'h0, 1'b1);
        @(posedge pclk); #1;
        chk("to_grant", grant, 2'b01);
        set_req(1'b1, 1'b1, 32'h0000_0200, 32'h3333_4444, 1'b0);
        @(posedge pclk); #1;
        for (int k = 0; k < TO; k++) begin
            @(negedge pclk);
            chk("to_m1_quiet", m1_pready, 1'b0);
            chk("to_m0_pready", m0_pready, (k == TO - 1));
            if (k == TO - 1) check_resp(1'b0);
            @(posedge pclk); #1;
        end
        chk("to_evt", timeout_evt, 1'b1);
        chk("to_psel_drop", psel, 1'b0);
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        s_pready = 1'b1; s_prdata = 32'hCAFE_0001; s_pslverr = 1'b0;
        sb_push(1'b1, 32'hCAFE_0001, 1'b0);
        @(posedge pclk); #1;
        chk("to_m1_grant", grant, 2'b10);
        chk("to_evt_pulse", timeout_evt, 1'b0);
        chk("to_m1_paddr", paddr, 32'h0000_0200);
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("to_m1_pready", m1_pready, 1'b1);
        check_resp(1'b1);
        @(posedge pclk); #1;
        set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Contention: both request continuously for four transfers.
        set_req(1'b0, 1'b1, 32'h0000_0300, 32'h0, 1'b0);
        set_req(1'b1, 1'b1, 32'h0000_0304, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            logic ep;
            ep = i[0];
            s_pready = 1'b1; s_prdata = 32'h5000_0000 + i;
            sb_push(ep, 32'h5000_0000 + i, 1'b0);
            @(posedge pclk); #1;
            chk("rr_grant", grant, ep ? 2'b10 : 2'b01);
            chk("rr_paddr", paddr, ep ? 32'h0000_0304 : 32'h0000_0300);
            @(negedge pclk);
            chk("rr_setup_quiet", m0_pready | m1_pready, 1'b0);
            @(posedge pclk); #1;
            @(negedge pclk);
            chk("rr_owner_pready", ep ? m1_pready : m0_pready, 1'b1);
            chk("rr_other_pready", ep ? m0_pready : m1_pready, 1'b0);
            check_resp(ep);
            @(posedge pclk); #1;
            chk("rr_idle_grant", grant, 2'b00);
        end
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge pclk); #1;

        // Asynchronous reset while port 1 is in a wait state.
        set_req(1'b1, 1'b1, 32'h0000_0400, 32'h7777_8888, 1'b1);
        s_pready = 1'b0;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        s_pready = 1'b1; s_prdata = 32'h9999_0000;
        #1;
        chk("rst_pre_pready", m1_pready, 1'b1);
        reset = 1'b1;
        #1;
        chk("arst_psel", psel, 1'b0);
        chk("arst_penable", penable, 1'b0);
        chk("arst_grant", grant, 2'b00);
        chk("arst_paddr", paddr, 32'h0);
        chk("arst_pwdata", pwdata, 32'h0);
        chk("arst_pwrite", pwrite, 1'b0);
        chk("arst_m1_pready", m1_pready, 1'b0);
        chk("arst_m1_prdata", m1_prdata, 32'h0);
        set_req(1'b0, 1'b1, 32'h0000_0500, 32'h0, 1'b0);
        s_prdata = 32'h0000_0ABC;
        sb_push(1'b0, 32'h0000_0ABC, 1'b0);
        @(negedge pclk);
        reset = 1'b0;
        @(posedge pclk); #1;
        chk("post_rst_grant", grant, 2'b01);
        @(posedge pclk); #1;
        @(negedge pclk);
        chk("post_rst_m0_pready", m0_pready, 1'b1);
        check_resp(1'b0);
        @(posedge pclk); #1;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        s_pready = 1'b0;
        repeat (4) @(posedge pclk);
        chk("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-requester APB arbiter that shares the bridge's single downstream APB master port between the AHB-to-APB bridge FSM (port 0) and a secondary configuration/debug APB master (port 1). Each requester sees a standard APB completer; the arbiter grants one at a time, round-robin, and replays the winner's transfer on the downstream bus with registered SETUP/ACCESS phases. It also enforces a wait-state timeout that aborts hung slaves with an error response, so neither requester can stall the bridge indefinitely.

## Interface
- DATA_WIDTH, 32, pwdata/prdata width
- ADDR_WIDTH, 32, paddr width
- TIMEOUT, 16, max ACCESS-phase cycles before abort; 0 disables timeout
- pclk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- m0_psel, m1_psel  in  1  requester select; high = request
- m0_penable, m1_penable  in  1  requester enable (monitored only, not used for arbitration)
- m0_paddr, m1_paddr  in  ADDR_WIDTH  requester address
- m0_pwrite, m1_pwrite  in  1  requester direction
- m0_pwdata, m1_pwdata  in  DATA_WIDTH  requester write data
- m0_prdata, m1_prdata  out  DATA_WIDTH  read data back to requester
- m0_pready, m1_pready  out  1  completion to requester
- m0_pslverr, m1_pslverr  out  1  error to requester
- psel, penable  out  1  downstream APB control (registered)
- paddr  out  ADDR_WIDTH  downstream address (registered)
- pwrite  out  1  downstream direction (registered)
- pwdata  out  DATA_WIDTH  downstream write data (registered)
- prdata  in  DATA_WIDTH  downstream read data
- pready, pslverr  in  1  downstream completion/error
- grant  out  2  one-hot owner; 2'b00 when idle (registered)
- timeout_evt  out  1  one-cycle pulse on timeout abort (registered)

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: request vector = {m1_psel, m0_psel}. None -> stay. One -> grant it. Both -> grant port indicated by priority pointer. On grant: latch winner's paddr/pwrite/pwdata into downstream registers, set grant, psel=1, penable=0, go SETUP; pointer <= other port.
- SETUP: penable<=1, go ACCESS. Unconditional, one cycle.
- ACCESS: downstream psel=1, penable=1, address/data held. Wait counter increments each cycle pready=0.
  - pready=1: granted mX_pready=1, mX_prdata=prdata, mX_pslverr=pslverr (combinational, same cycle). Next edge: psel/penable/paddr/pwrite/pwdata/grant <= 0, go IDLE.
  - pready=0 and counter==TIMEOUT-1 (TIMEOUT≠0): abort. Same cycle mX_pready=1, mX_pslverr=1, mX_prdata=0; next edge timeout_evt=1 for one cycle, downstream cleared, go IDLE.
- Non-granted requester: mX_pready=0, mX_pslverr=0, mX_prdata=0 at all times. Its held psel remains a pending request.
- Outside ACCESS, all mX_pready/mX_pslverr/mX_prdata are 0.
- Counter width clog2(TIMEOUT+1); cleared on entering ACCESS; saturates, never wraps.
- Priority pointer resets to port 0; it changes only on a grant, never on completion.

## Timing
- Reset (asynchronous, any state, including mid-transfer): state IDLE; psel, penable, pwrite, grant, timeout_evt = 0; paddr, pwdata = 0; counter 0; pointer = port 0. Upstream outputs 0. The aborted transfer is not retried.
- Latency: request sampled at edge 0. Downstream SETUP visible cycle 1, ACCESS cycle 2. With a zero-wait slave, mX_pready is high in cycle 2. Minimum transfer is 3 cycles including IDLE.
- A back-to-back request from the same port (psel held after pready) is re-arbitrated in the IDLE cycle. With the other port pending, round-robin gives that port the bus.
- Simultaneous pready=1 and timeout count reached: pready wins, normal completion, no timeout_evt.
- Upstream inputs are sampled only at grant. Changes during SETUP/ACCESS are ignored.

## Test plan
- Single write: m0_psel=1, paddr=0x0000_0010, pwdata=0xDEAD_BEEF, pwrite=1, slave pready=1 immediately -> downstream psel cycle 1, penable cycle 2 with paddr=0x10, pwdata=0xDEADBEEF; m0_pready=1 cycle 2; grant=01 cycles 1–2.
- Contention: m0_psel and m1_psel rise together, repeated back-to-back for 4 transfers -> grant sequence 01,10,01,10; m1 sees no pready while m0 owns the bus.
- Wait states: m1 read at 0x40, slave holds pready=0 for 3 ACCESS cycles, then pready=1, prdata=0x1234_5678 -> m1_pready only on the 4th ACCESS cycle with m1_prdata=0x12345678; no timeout_evt.
- Timeout: TIMEOUT=4, slave never asserts pready -> 4th ACCESS cycle m0_pready=1, m0_pslverr=1, m0_prdata=0; timeout_evt pulses next cycle; psel drops; a pending m1 is granted afterwards.
- Slave error and race: pslverr=1 with pready=1 on the TIMEOUT-th cycle -> normal completion with pslverr=1 forwarded, no timeout_evt.
- Reset mid-ACCESS: assert reset during the wait state -> all outputs 0 immediately (asynchronous); after release, simultaneous requests grant port 0 first.
